// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_sb                                                                |
// | Register file with a per-register pending (scoreboard) bit, multi-port     |
// | combinational reads, optional write forwarding and a pending counter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_file_sb #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    localparam logic [AW:0] c_NREGS = NREGS[AW:0];
    localparam logic        c_ZERO  = (ZERO_REG != 0);
    localparam logic        c_BYP   = (BYPASS != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    logic w_wr_ok;
    logic w_iss_ok;
    logic w_iss_busy;
    logic w_set;
    logic w_dec;

    // A register is "tracked" when it really stores data and can be pending.
    function automatic logic tracked(input logic [AW-1:0] a);
        return ({1'b0, a} < c_NREGS) && !(c_ZERO && (a == '0));
    endfunction

    assign w_wr_ok    = wr_en && tracked(wr_addr);
    assign w_iss_ok   = tracked(iss_addr);
    assign w_iss_busy = w_iss_ok && busy_q[iss_addr];
    // Reset forces readiness so a requester is never stalled by stale flags.
    assign iss_ready  = !flush && (rst || !w_iss_busy);
    assign w_set      = iss_en && iss_ready && w_iss_ok;
    assign w_dec      = w_wr_ok && busy_q[wr_addr];

    always_comb begin
        busy_d = busy_q;
        if (w_wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (w_set) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Accepted issue implies the target was idle, so inc and dec never collide.
    always_comb begin
        busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, w_set} - {{AW{1'b0}}, w_dec};
        if (flush) begin
            busy_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (w_wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_ra_ok;
        logic          w_byp;

        assign w_ra    = rd_addr[k*AW +: AW];
        assign w_ra_ok = tracked(w_ra);
        assign w_byp   = c_BYP && w_wr_ok && (wr_addr == w_ra);

        assign rd_data[k*XLEN +: XLEN] = !w_ra_ok ? '0 :
                                         w_byp    ? wr_data : regs_q[w_ra];
        assign rd_busy[k] = w_ra_ok && !w_byp && busy_q[w_ra];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_file_sb                                                             |
// | Self-checking bench: DUT0 (32 regs, x0 hardwired, forwarding) and DUT1     |
// | (24 regs, no hardwired x0, no forwarding) against a behavioural model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [63:0] rdata [2];
    logic [1:0]  rbusy [2];
    logic        rdy   [2];
    logic [5:0]  cnt   [2];

    int tests;
    int failed;
    logic chk_on;

    assign rd_addr = {ra1, ra0};

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdata[0]), .rd_busy(rbusy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ready(rdy[0]), .flush(flush), .busy_cnt(cnt[0])
    );

    reg_file_sb #(.XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdata[1]), .rd_busy(rbusy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ready(rdy[1]), .flush(flush), .busy_cnt(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mreg  [2][32];
    logic        mbusy [2][32];

    function automatic logic m_ok(input int d, input logic [4:0] a);
        if (d == 0) return a != 5'd0;
        return a < 5'd24;
    endfunction

    function automatic logic [31:0] m_rdata(input int d, input logic [4:0] a);
        if (!m_ok(d, a)) return 32'h0;
        if (d == 0 && wr_en && wr_addr == a) return wr_data;
        return mreg[d][a];
    endfunction

    function automatic logic m_rbusy(input int d, input logic [4:0] a);
        if (!m_ok(d, a)) return 1'b0;
        if (d == 0 && wr_en && wr_addr == a) return 1'b0;
        return mbusy[d][a];
    endfunction

    function automatic logic m_ready(input int d);
        if (flush) return 1'b0;
        if (rst) return 1'b1;
        return !(m_ok(d, iss_addr) && mbusy[d][iss_addr]);
    endfunction

    function automatic int m_cnt(input int d);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[d][i]);
        return n;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    mreg[d][i]  = 32'h0;
                    mbusy[d][i] = 1'b0;
                end
            end else begin
                logic r;
                r = m_ready(d);
                if (wr_en && m_ok(d, wr_addr)) begin
                    mreg[d][wr_addr]  = wr_data;
                    mbusy[d][wr_addr] = 1'b0;
                end
                if (iss_en && r && m_ok(d, iss_addr)) mbusy[d][iss_addr] = 1'b1;
                if (flush) for (int i = 0; i < 32; i++) mbusy[d][i] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d rd0 data", d), {32'h0, rdata[d][31:0]},  {32'h0, m_rdata(d, ra0)});
                chk($sformatf("dut%0d rd1 data", d), {32'h0, rdata[d][63:32]}, {32'h0, m_rdata(d, ra1)});
                chk($sformatf("dut%0d rd_busy", d), {62'h0, rbusy[d]}, {62'h0, m_rbusy(d, ra1), m_rbusy(d, ra0)});
                chk($sformatf("dut%0d iss_ready", d), {63'h0, rdy[d]}, {63'h0, m_ready(d)});
                chk($sformatf("dut%0d busy_cnt", d), {58'h0, cnt[d]}, 64'(m_cnt(d)));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        tests = 0; failed = 0; chk_on = 1'b0;
        rst = 1'b1; idle();
        ra0 = '0; ra1 = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; chk_on = 1'b1;

        iss_addr = 5'd5; #2;
        chk("reset busy_cnt", 64'(cnt[0]), 64'd0);
        chk("reset iss_ready", 64'(rdy[0]), 64'd1);
        chk("reset x0 read", 64'(rdata[0][31:0]), 64'd0);

        // write then dual-port read
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
        ra0 = 5'd5; ra1 = 5'd5; #2;
        chk("wr/rd port0", 64'(rdata[0][31:0]), 64'hDEADBEEF);
        chk("wr/rd port1", 64'(rdata[0][63:32]), 64'hDEADBEEF);
        chk("wr/rd busy", 64'(rbusy[0]), 64'd0);

        // forwarding vs none
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'h12345678; ra0 = 5'd7; #2;
        chk("bypass new", 64'(rdata[0][31:0]), 64'h12345678);
        chk("no-bypass old", 64'(rdata[1][31:0]), 64'h0);
        tick(); #2;
        chk("no-bypass after", 64'(rdata[1][31:0]), 64'h12345678);

        // scoreboard issue / refuse / release
        iss_en = 1; iss_addr = 5'd3; #2;
        chk("issue x3 ready", 64'(rdy[0]), 64'd1);
        tick();
        iss_en = 1; iss_addr = 5'd3; #2;
        chk("reissue cnt", 64'(cnt[0]), 64'd1);
        chk("reissue refused", 64'(rdy[0]), 64'd0);
        tick(); #2;
        chk("refused cnt", 64'(cnt[0]), 64'd1);
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'h1; ra0 = 5'd3; tick(); #2;
        chk("release cnt", 64'(cnt[0]), 64'd0);
        chk("release busy", 64'(rbusy[0][0]), 64'd0);
        chk("release data", 64'(rdata[0][31:0]), 64'h1);

        // issue and write same register
        iss_en = 1; iss_addr = 5'd9; wr_en = 1; wr_addr = 5'd9; wr_data = 32'hA; tick();
        ra0 = 5'd9; #2;
        chk("iss+wr data", 64'(rdata[0][31:0]), 64'hA);
        chk("iss+wr busy", 64'(rbusy[0][0]), 64'd1);
        chk("iss+wr cnt", 64'(cnt[0]), 64'd1);

        // flush with write, then x0 handling
        iss_en = 1; iss_addr = 5'd1; tick();
        iss_en = 1; iss_addr = 5'd2; tick();
        iss_en = 1; iss_addr = 5'd4; tick(); #2;
        chk("pre-flush cnt", 64'(cnt[0]), 64'd4);
        flush = 1; wr_en = 1; wr_addr = 5'd2; wr_data = 32'h55; tick();
        ra0 = 5'd2; #2;
        chk("flush cnt", 64'(cnt[0]), 64'd0);
        chk("flush data", 64'(rdata[0][31:0]), 64'h55);
        iss_en = 1; iss_addr = 5'd0; wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFF; #2;
        chk("x0 iss_ready", 64'(rdy[0]), 64'd1);
        tick();
        ra0 = 5'd0; #2;
        chk("x0 read", 64'(rdata[0][31:0]), 64'h0);
        chk("x0 busy", 64'(rbusy[0][0]), 64'd0);
        chk("x0 cnt", 64'(cnt[0]), 64'd0);
        chk("plain x0 data", 64'(rdata[1][31:0]), 64'hFF);
        chk("plain x0 cnt", 64'(cnt[1]), 64'd1);

        // out-of-range register on the 24-entry instance
        iss_en = 1; iss_addr = 5'd30; wr_en = 1; wr_addr = 5'd30; wr_data = 32'hAB; tick();
        ra1 = 5'd30; #2;
        chk("oor read", 64'(rdata[1][63:32]), 64'h0);
        chk("oor busy", 64'(rbusy[1][1]), 64'd0);
        chk("oor cnt", 64'(cnt[1]), 64'd1);
        chk("in-range x30", 64'(rdata[0][63:32]), 64'hAB);

        // reset in the middle of activity
        iss_en = 1; iss_addr = 5'd10; wr_en = 1; wr_addr = 5'd30; wr_data = 32'hCD; tick();
        iss_en = 1; iss_addr = 5'd11; wr_en = 1; wr_addr = 5'd6; wr_data = 32'h77; tick();
        iss_en = 1; iss_addr = 5'd12; tick();
        ra0 = 5'd6; #2;
        chk("pre-rst cnt", 64'(cnt[0]), 64'd3);
        chk("pre-rst x6", 64'(rdata[0][31:0]), 64'h77);
        rst = 1; wr_en = 1; wr_addr = 5'd13; wr_data = 32'h99; iss_en = 1; iss_addr = 5'd10; #2;
        chk("in-rst iss_ready", 64'(rdy[0]), 64'd1);
        tick();
        rst = 0; ra0 = 5'd6; ra1 = 5'd13; iss_addr = 5'd10; #2;
        chk("post-rst x6", 64'(rdata[0][31:0]), 64'h0);
        chk("post-rst x13", 64'(rdata[0][63:32]), 64'h0);
        chk("post-rst cnt", 64'(cnt[0]), 64'd0);
        chk("post-rst ready", 64'(rdy[0]), 64'd1);
        chk("post-rst cnt1", 64'(cnt[1]), 64'd0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and one reset, `rst`; `rst` SHALL be synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers (2..64).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, register 0 hardwired to zero when 1.
- BYPASS, 1, same-cycle write-to-read forwarding when 1.
- AW is derived as clog2(NREGS).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- rd_addr, in, NRD*AW, packed read addresses; port k is bits [k*AW +: AW].
- rd_data, out, NRD*XLEN, packed read data.
- rd_busy, out, NRD, pending-write flag per read port.
- wr_en, in, 1, writeback enable.
- wr_addr, in, AW, writeback register.
- wr_data, in, XLEN, writeback data.
- iss_en, in, 1, issue request: mark a register as pending.
- iss_addr, in, AW, register to mark.
- iss_ready, out, 1, issue acceptance.
- flush, in, 1, clear all pending flags.
- busy_cnt, out, AW+1, number of pending registers.

Function
REQ-004 Storage SHALL be NREGS x XLEN data words plus NREGS busy bits.
REQ-005 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]].
REQ-006 When BYPASS=1, wr_en=1 and wr_addr == rd_addr[k] (valid, non-zero), port k SHALL return wr_data with rd_busy[k]=0 in the same cycle.
REQ-007 When wr_en=1 at a clk rising edge, reg[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear.
REQ-008 A write to a register whose busy bit is 0 SHALL be legal and SHALL update the data.
REQ-009 iss_ready SHALL be 1 only when flush=0 and busy[iss_addr]=0.
REQ-010 iss_ready SHALL depend only on state, flush and iss_addr, never on wr_*.
REQ-011 An issue SHALL be accepted on a rising edge where iss_en=1 and iss_ready=1; acceptance SHALL set busy[iss_addr].
REQ-012 If iss_en=1 and iss_ready=0, the request SHALL be ignored and no state SHALL change from it; the requester holds it.
REQ-013 If an accepted issue and a write target the same register in one cycle, the issue SHALL win: data updates and busy ends at 1.
REQ-014 flush=1 SHALL clear all busy bits at the edge and leave data unchanged.
REQ-015 A write in a flush cycle SHALL still update data.
REQ-016 When ZERO_REG=1, register 0 SHALL always behave as follows:
- reads return 0 with busy=0;
- writes are ignored;
- an issue to it is accepted (iss_ready=1) without setting busy.
REQ-017 Addresses >= NREGS SHALL behave as follows:
- reads return 0 with busy=0;
- writes are ignored;
- issue is accepted and ignored.
REQ-018 busy_cnt SHALL be a registered output equal to the popcount of the busy bits after each edge, updated incrementally in the range 0..NREGS.
REQ-019 Read ports SHALL be fully independent; identical addresses on multiple ports SHALL return identical results.

Reset
REQ-020 With rst=1 at an edge, all data words SHALL become 0, all busy bits 0 and busy_cnt 0.
REQ-021 rst SHALL override wr_en, iss_en and flush in the same cycle.
REQ-022 During and immediately after reset, iss_ready SHALL be 1 for any valid address.
REQ-023 Reset asserted mid-operation SHALL discard all pending state with no partial update.

Verification
REQ-024 Write/read:
- Stimulus: write x5=0xDEADBEEF, then read it on port 0 and port 1 the next cycle.
- Required: both ports return 0xDEADBEEF with rd_busy=0.
REQ-025 Bypass:
- Stimulus: BYPASS=1, wr_en with x7=0x12345678 while rd_addr[0]=7 in the same cycle.
- Required: rd_data[0]=0x12345678 in that cycle.
- Also check BYPASS=0: rd_data[0] shows the old value in that cycle.
REQ-026 Scoreboard:
- Stimulus: issue x3; issue x3 again next cycle; then write x3=0x1.
- Required: busy_cnt=1 and the second issue is refused (iss_ready=0).
- Required: after the write, busy clears and busy_cnt=0.
REQ-027 Simultaneous issue and write:
- Stimulus: issue x9 and write x9=0xA in the same cycle.
- Required: x9 reads 0xA, rd_busy=1, busy_cnt=1.
REQ-028 Flush and zero register:
- Stimulus: issue x1, x2, x4, then flush with a write to x2=0x55.
- Required: busy_cnt=0 and x2=0x55.
- Stimulus: issue x0 and write x0=0xFF.
- Required: x0 reads 0 with busy_cnt unchanged.
REQ-029 Reset mid-operation:
- Stimulus: with 3 registers pending and x6=0x77, assert rst together with wr_en.
- Required: all reads return 0, busy_cnt=0, iss_ready=1.
